// File: rtl/speckey_pkg.sv
// Shared definitions for the SPECKEY stream wrapper.
//   BLK_W   : core block width in bits
//   fsm_e   : wrapper sequencing states
//   nwords(): number of stream words per block
package speckey_pkg;

  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_EMIT    = 2'd2
  } fsm_e;

  function automatic int unsigned nwords(input int unsigned word_w);
    return BLK_W / word_w;
  endfunction

endpackage

// File: rtl/speckey_stream_wrap_if.sv
// Stream-side bundle of the SPECKEY wrapper: input word channel, output word channel and the
// per-block mode bit.
//   master : upstream/downstream environment (drives in_valid/in_data/mode_i/out_ready)
//   slave  : the wrapper (drives in_ready/out_valid/out_data)
// WORD_W must match the WORD_W of the wrapper it is connected to.
interface speckey_stream_wrap_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic              mode_i;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output mode_i, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode_i, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/speckey_word_shreg.sv
// Block-wide register that either parallel-loads a full block or shifts left by one word,
// inserting a new word at the bottom. Load has priority over shift.
//   clk, rst     : clock, asynchronous active-high reset (clears to zero)
//   load_i       : parallel load of load_data_i
//   shift_i      : shift left by WORD_W, shift_in_i enters bits [WORD_W-1:0]
//   data_o       : current register contents
module speckey_word_shreg
  import speckey_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [BLK_W-1:0]  load_data_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] shift_in_i,
  output logic [BLK_W-1:0]  data_o
);

  logic [BLK_W-1:0] data_q, data_d, shifted;

  if (WORD_W == BLK_W) begin : g_whole
    assign shifted = shift_in_i;
  end else begin : g_slice
    assign shifted = {data_q[BLK_W-WORD_W-1:0], shift_in_i};
  end

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/speckey_stream_wrap.sv
// Sequential front/back end for the combinational 128-bit SPECKEY core.
// Packs WORD_W-bit words MSB-first into a block, presents it to the core for CORE_WAIT cycles,
// captures the result and streams it back out MSB-first. One block in flight at a time.
//   clk, rst      : clock, asynchronous active-high reset
//   stream        : slave side of speckey_stream_wrap_if (mode_i, in_*, out_*)
//   core_mode     : mode bit to the core (0=encrypt, 1=decrypt)
//   core_state_i  : block to the core (registered, stable while the core evaluates)
//   core_state_o  : result from the core
//   iv_load, iv_i : chaining-value load (used only when SPECKEY_CBC_EN is defined)
//   busy          : high while evaluating or emitting
// Build option: define SPECKEY_CBC_EN to enable CBC chaining through a 128-bit cv register.
module speckey_stream_wrap
  import speckey_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CORE_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  speckey_stream_wrap_if.slave stream,
  output logic                 core_mode,
  output logic [BLK_W-1:0]     core_state_i,
  input  logic [BLK_W-1:0]     core_state_o,
  input  logic                 iv_load,
  input  logic [BLK_W-1:0]     iv_i,
  output logic                 busy
);

  localparam int unsigned NW  = nwords(WORD_W);
  localparam int unsigned WcW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned EcW = $clog2(CORE_WAIT + 1);

  fsm_e state_q, state_d;

  logic [WcW-1:0]   word_cnt_q, word_cnt_d;
  logic [EcW-1:0]   eval_cnt_q, eval_cnt_d;
  logic             mode_q, mode_d;
  logic [BLK_W-1:0] core_state_q, core_state_d;

  logic             in_rdy, out_vld, busy_c;
  logic             in_fire, out_fire, last_word;
  logic             eval_load, eval_done;
  logic [BLK_W-1:0] inbuf, outbuf, core_in, result;

  assign in_fire   = stream.in_valid & in_rdy;
  assign out_fire  = out_vld & stream.out_ready;
  assign last_word = (word_cnt_q == WcW'(NW - 1));
  // First EVAL cycle registers the core input; it is then held for CORE_WAIT cycles.
  assign eval_load = (state_q == S_EVAL) && (eval_cnt_q == '0);
  assign eval_done = (state_q == S_EVAL) && (eval_cnt_q == EcW'(CORE_WAIT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (in_fire && last_word) state_d = S_EVAL;
      S_EVAL:    if (eval_done) state_d = S_EMIT;
      S_EMIT:    if (out_fire && last_word) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    busy_c  = 1'b0;
    unique case (state_q)
      S_COLLECT: in_rdy = 1'b1;
      S_EVAL:    busy_c = 1'b1;
      S_EMIT: begin
        out_vld = 1'b1;
        busy_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, mode latch and core input register
  always_comb begin
    word_cnt_d   = word_cnt_q;
    eval_cnt_d   = '0;
    mode_d       = mode_q;
    core_state_d = core_state_q;
    // in_fire and out_fire are never both high, so one word counter serves both sides.
    if (in_fire || out_fire) begin
      word_cnt_d = last_word ? '0 : word_cnt_q + WcW'(1);
    end
    if (in_fire && (word_cnt_q == '0)) begin
      mode_d = stream.mode_i;
    end
    if ((state_q == S_EVAL) && !eval_done) begin
      eval_cnt_d = eval_cnt_q + EcW'(1);
    end
    if (eval_load) begin
      core_state_d = core_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q   <= '0;
      eval_cnt_q   <= '0;
      mode_q       <= 1'b0;
      core_state_q <= '0;
    end else begin
      word_cnt_q   <= word_cnt_d;
      eval_cnt_q   <= eval_cnt_d;
      mode_q       <= mode_d;
      core_state_q <= core_state_d;
    end
  end

`ifdef SPECKEY_CBC_EN
  logic [BLK_W-1:0] cv_q, cv_d;

  always_comb begin
    cv_d = cv_q;
    if (iv_load && (state_q == S_COLLECT) && (word_cnt_q == '0)) begin
      cv_d = iv_i;
    end else if (eval_done) begin
      // Encrypt chains on the ciphertext, decrypt on the incoming ciphertext block.
      cv_d = mode_q ? inbuf : core_state_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv_q <= '0;
    end else begin
      cv_q <= cv_d;
    end
  end

  assign core_in = mode_q ? inbuf : (inbuf ^ cv_q);
  assign result  = mode_q ? (core_state_o ^ cv_q) : core_state_o;
`else
  logic unused_cbc;
  assign unused_cbc = ^{iv_load, iv_i};
  assign core_in    = inbuf;
  assign result     = core_state_o;
`endif

  speckey_word_shreg #(
    .WORD_W (WORD_W)
  ) u_inbuf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (in_fire),
    .shift_in_i  (stream.in_data),
    .data_o      (inbuf)
  );

  speckey_word_shreg #(
    .WORD_W (WORD_W)
  ) u_outbuf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (eval_done),
    .load_data_i (result),
    .shift_i     (out_fire),
    .shift_in_i  ('0),
    .data_o      (outbuf)
  );

  assign stream.in_ready  = in_rdy;
  assign stream.out_valid = out_vld;
  assign stream.out_data  = outbuf[BLK_W-1 -: WORD_W];
  assign core_state_i     = core_state_q;
  assign core_mode        = mode_q;
  assign busy             = busy_c;

endmodule

// File: tb/tb_speckey_stream_wrap.sv
// Self-checking bench for speckey_stream_wrap with a stub core (state_o = state_i ^ A5..A5).
// Instance A uses CORE_WAIT=1, instance B uses CORE_WAIT=3.
// CBC checks are compiled in when SPECKEY_CBC_EN is defined.
module tb_speckey_stream_wrap;
  import speckey_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NW = BLK_W / W;
  localparam logic [BLK_W-1:0] KEY = {4{32'hA5A5A5A5}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  speckey_stream_wrap_if #(.WORD_W(W)) sa ();
  speckey_stream_wrap_if #(.WORD_W(W)) sb ();

  logic             core_mode_a, core_mode_b, busy_a, busy_b;
  logic [BLK_W-1:0] cs_i_a, cs_o_a, cs_i_b, cs_o_b;
  logic             iv_load, iv_load_b;
  logic [BLK_W-1:0] iv, iv_b;

  assign cs_o_a = cs_i_a ^ KEY;
  assign cs_o_b = cs_i_b ^ KEY;

  speckey_stream_wrap #(.WORD_W(W), .CORE_WAIT(1)) dut_a (
    .clk(clk), .rst(rst), .stream(sa), .core_mode(core_mode_a), .core_state_i(cs_i_a),
    .core_state_o(cs_o_a), .iv_load(iv_load), .iv_i(iv), .busy(busy_a)
  );

  speckey_stream_wrap #(.WORD_W(W), .CORE_WAIT(3)) dut_b (
    .clk(clk), .rst(rst), .stream(sb), .core_mode(core_mode_b), .core_state_i(cs_i_b),
    .core_state_o(cs_o_b), .iv_load(iv_load_b), .iv_i(iv_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

`ifdef SPECKEY_CBC_EN
  logic [BLK_W-1:0] model_cv = '0;
`endif

  // Block-level reference: what the wrapper plus stub core should return for one block.
  function automatic logic [BLK_W-1:0] model_block(input logic [BLK_W-1:0] blk, input logic mode);
    logic [BLK_W-1:0] r;
`ifdef SPECKEY_CBC_EN
    if (!mode) begin
      r = (blk ^ model_cv) ^ KEY;
      model_cv = r;
    end else begin
      r = (blk ^ KEY) ^ model_cv;
      model_cv = blk;
    end
`else
    r = blk ^ KEY;
    if (mode) r = blk ^ KEY;
`endif
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode_pat: 0 = hold mode, 1 = toggle on later words, 2 = random on later words
  task automatic send_block(input logic [BLK_W-1:0] blk, input logic mode, input int mode_pat,
                            input bit gaps, input int nsend);
    for (int i = 0; i < nsend; i++) begin
      int n;
      int g;
      g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) @(negedge clk);
      sa.in_valid = 1'b1;
      sa.in_data  = blk[BLK_W-1-i*W -: W];
      if (i == 0) sa.mode_i = mode;
      else if (mode_pat == 1) sa.mode_i = mode ^ ((i % 2) == 1);
      else if (mode_pat == 2) sa.mode_i = 1'($urandom_range(0, 1));
      else sa.mode_i = mode;
      n = 0;
      while (sa.in_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL in_ready_timeout word=%0d in_ready=%b required=1", i, sa.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      sa.in_valid = 1'b0;
    end
  endtask

  // bp: 0 = always ready, 1 = random ready, 2 = five-cycle stall on word 1
  task automatic recv_block(input int bp, input logic exp_mode, output logic [BLK_W-1:0] got);
    int  n = 0;
    int  idx = 0;
    int  stall = 0;
    bit  holding = 0;
    bit  rdy;
    logic [W-1:0] held = '0;
    got = '0;
    // Stray out_ready while out_valid is low must have no effect.
    while (sa.out_valid !== 1'b1 && n < 100) begin
      checks++;
      if (sa.in_ready !== 1'b0 || busy_a !== 1'b1 || core_mode_a !== exp_mode) begin
        errors++;
        $display("FAIL eval_ctrl in_ready=%b busy=%b core_mode=%b required 0 1 %b",
                 sa.in_ready, busy_a, core_mode_a, exp_mode);
      end
      sa.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL latency edges=%0d required=2", n);
    end
    n = 0;
    while (idx < NW && n < 200) begin
      checks++;
      if (sa.out_valid !== 1'b1 || sa.in_ready !== 1'b0 || busy_a !== 1'b1 ||
          core_mode_a !== exp_mode) begin
        errors++;
        $display("FAIL emit_ctrl out_valid=%b in_ready=%b busy=%b core_mode=%b required 1 0 1 %b",
                 sa.out_valid, sa.in_ready, busy_a, core_mode_a, exp_mode);
      end
      if (holding) begin
        checks++;
        if (sa.out_data !== held) begin
          errors++;
          $display("FAIL hold_data out_data=%h required=%h", sa.out_data, held);
        end
      end
      if (bp == 0) rdy = 1'b1;
      else if (bp == 1) rdy = ($urandom_range(0, 2) != 0);
      else rdy = !(idx == 1 && stall < 5);
      if (!rdy) stall++;
      sa.out_ready = rdy;
      if (rdy) begin
        got[BLK_W-1-idx*W -: W] = sa.out_data;
        idx++;
        holding = 1'b0;
      end else begin
        held = sa.out_data;
        holding = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    sa.out_ready = 1'b0;
    checks++;
    if (idx != NW) begin
      errors++;
      $display("FAIL emit_timeout words=%0d required=%0d", idx, NW);
    end
    checks++;
    if (sa.out_valid !== 1'b0 || sa.in_ready !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL after_emit out_valid=%b in_ready=%b busy=%b required 0 1 0",
               sa.out_valid, sa.in_ready, busy_a);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (sa.in_ready !== 1'b1 || sa.out_valid !== 1'b0 || sa.out_data !== '0 ||
        cs_i_a !== '0 || core_mode_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready=%b out_valid=%b out_data=%h core_state_i=%h core_mode=%b busy=%b required 1 0 0 0 0 0",
               tag, sa.in_ready, sa.out_valid, sa.out_data, cs_i_a, core_mode_a, busy_a);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset_a");
    checks++;
    if (sb.in_ready !== 1'b1 || sb.out_valid !== 1'b0 || cs_i_b !== '0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b in_ready=%b out_valid=%b core_state_i=%h busy=%b required 1 0 0 0",
               sb.in_ready, sb.out_valid, cs_i_b, busy_b);
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_release");
  endtask

  task automatic test_ecb;
    logic [BLK_W-1:0] blk, got, expv;
    blk  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    expv = 128'hA5B48796_E1F0C3D2_2D3C0F1E_69784B5A;
    void'(model_block(blk, 1'b0));
    send_block(blk, 1'b0, 0, 1'b0, NW);
    recv_block(0, 1'b0, got);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL ecb_vector got=%h required=%h", got, expv);
    end
  endtask

  task automatic test_backpressure;
    logic [BLK_W-1:0] blk, got, expv;
    blk  = rand_blk();
    expv = model_block(blk, 1'b0);
    send_block(blk, 1'b0, 0, 1'b1, NW);
    recv_block(2, 1'b0, got);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL backpressure got=%h required=%h", got, expv);
    end
  endtask

  task automatic test_mode;
    logic [BLK_W-1:0] blk, got, expv;
    blk  = rand_blk();
    expv = model_block(blk, 1'b1);
    send_block(blk, 1'b1, 1, 1'b0, NW);
    recv_block(0, 1'b1, got);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL mode_block got=%h required=%h", got, expv);
    end
  endtask

  task automatic test_reset_mid_block;
    logic [BLK_W-1:0] blk, got, expv;
    send_block(rand_blk(), 1'b1, 0, 1'b0, 2);
    rst = 1'b1;
    #1;
    check_reset_values("reset_mid");
    @(negedge clk);
    rst = 1'b0;
`ifdef SPECKEY_CBC_EN
    model_cv = '0;
`endif
    @(negedge clk);
    check_reset_values("reset_mid_release");
    blk  = rand_blk();
    expv = model_block(blk, 1'b0);
    send_block(blk, 1'b0, 0, 1'b0, NW);
    recv_block(0, 1'b0, got);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL after_reset_block got=%h required=%h", got, expv);
    end
  endtask

  task automatic test_random;
    for (int b = 0; b < 6; b++) begin
      logic [BLK_W-1:0] blk, got, expv;
      logic m;
      blk  = rand_blk();
      m    = 1'($urandom_range(0, 1));
      expv = model_block(blk, m);
      send_block(blk, m, 2, 1'b1, NW);
      recv_block(1, m, got);
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL random_block%0d got=%h required=%h", b, got, expv);
      end
    end
  endtask

`ifdef SPECKEY_CBC_EN
  task automatic test_cbc;
    logic [BLK_W-1:0] got;
    iv_load = 1'b1;
    iv      = {BLK_W{1'b1}};
    @(negedge clk);
    iv_load = 1'b0;
    iv      = '0;
    model_cv = {BLK_W{1'b1}};
    void'(model_block('0, 1'b0));
    send_block('0, 1'b0, 0, 1'b0, NW);
    recv_block(0, 1'b0, got);
    checks++;
    if (got !== {16{8'h5A}}) begin
      errors++;
      $display("FAIL cbc_block1 got=%h required=%h", got, {16{8'h5A}});
    end
    void'(model_block('0, 1'b0));
    send_block('0, 1'b0, 0, 1'b0, NW);
    recv_block(0, 1'b0, got);
    checks++;
    if (got !== {BLK_W{1'b1}}) begin
      errors++;
      $display("FAIL cbc_block2 got=%h required=%h", got, {BLK_W{1'b1}});
    end
  endtask
`endif

  task automatic test_core_wait;
    logic [BLK_W-1:0] blk, got;
    int n;
    blk = rand_blk();
    got = '0;
    for (int i = 0; i < NW; i++) begin
      sb.in_valid = 1'b1;
      sb.in_data  = blk[BLK_W-1-i*W -: W];
      sb.mode_i   = 1'b0;
      n = 0;
      while (sb.in_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL cw_in_ready_timeout word=%0d", i);
      end
      @(posedge clk);
      @(negedge clk);
      sb.in_valid = 1'b0;
    end
    n = 0;
    sb.out_ready = 1'b1;
    while (sb.out_valid !== 1'b1 && n < 100) begin
      if (n >= 1) begin
        checks++;
        if (cs_i_b !== blk || busy_b !== 1'b1) begin
          errors++;
          $display("FAIL cw_state cycle=%0d core_state_i=%h busy=%b required=%h 1",
                   n, cs_i_b, busy_b, blk);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL cw_latency edges=%0d required=4", n);
    end
    for (int i = 0; i < NW && sb.out_valid === 1'b1; i++) begin
      got[BLK_W-1-i*W -: W] = sb.out_data;
      @(negedge clk);
    end
    sb.out_ready = 1'b0;
    checks++;
    if (got !== (blk ^ KEY) || sb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cw_block got=%h out_valid=%b required=%h 0", got, sb.out_valid, blk ^ KEY);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sa.in_valid  = 1'b0;
    sa.in_data   = '0;
    sa.mode_i    = 1'b0;
    sa.out_ready = 1'b0;
    sb.in_valid  = 1'b0;
    sb.in_data   = '0;
    sb.mode_i    = 1'b0;
    sb.out_ready = 1'b0;
    iv_load      = 1'b0;
    iv           = '0;
    iv_load_b    = 1'b0;
    iv_b         = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_ecb;
    test_backpressure;
    test_mode;
    test_reset_mid_block;
    test_random;
`ifdef SPECKEY_CBC_EN
    test_cbc;
`endif
    test_core_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
